// File: rtl/calc_display_pkg.sv
// Shared calculator-family definitions: display FSM states, blank code and
// the active-low seven-segment table ({g,f,e,d,c,b,a}).
package calc_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } calc_state_t;

  localparam int          BIN_W     = 8;
  localparam int          BCD_W     = 12;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0010000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b1000110;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/calc_display_bin2bcd.sv
// Sequential double-dabble: eight adjust-and-shift steps after a start pulse.
// done marks the final shift cycle; bcd holds the result from the next cycle on.
module bin2bcd_seq
  import calc_display_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BIN_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  logic [BIN_W-1:0] bin_sr;
  logic [BCD_W-1:0] bcd_sr;
  logic [BCD_W-1:0] bcd_adj;
  logic [2:0]       iter;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  always_comb begin
    bcd_adj = {add3(bcd_sr[11:8]), add3(bcd_sr[7:4]), add3(bcd_sr[3:0])};
  end

  assign done = busy && (iter == 3'd7);
  assign bcd  = bcd_sr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= 1'b0;
      iter <= 3'd0;
    end else if (start && !busy) begin
      busy <= 1'b1;
      iter <= 3'd0;
    end else if (busy) begin
      iter <= iter + 3'd1;
      if (iter == 3'd7) busy <= 1'b0;
    end
  end

  // datapath: load on start, adjust-then-shift while busy
  always_ff @(posedge clk) begin
    if (start && !busy) begin
      bin_sr <= value;
      bcd_sr <= '0;
    end else if (busy) begin
      {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
    end
  end

endmodule

// File: rtl/calc_display.sv
// Four-digit multiplexed seven-segment display for the calculator result,
// decimal (leading-zero blanked) or hex, re-converted only when the input changes.
module calc_display
  import calc_display_pkg::*;
#(
  parameter int REFRESH_CNT = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] dataIn,
  input  logic       hexMode,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       busy
);

  localparam int             CW   = (REFRESH_CNT > 1) ? $clog2(REFRESH_CNT) : 1;
  localparam logic [CW-1:0]  LAST = CW'(REFRESH_CNT - 1);

  calc_state_t state, state_nxt;

  logic        conv_start, conv_busy, conv_done;
  logic [11:0] conv_bcd;

  logic        shown_vld, shown_mode;
  logic [7:0]  shown_val;
  logic        cap_mode;
  logic [7:0]  cap_val;
  logic [15:0] digs, new_digs;
  logic [3:0]  blank, new_blank;
  logic        differs;

  logic [CW-1:0] scan_cnt;
  logic [1:0]    idx;

  bin2bcd_seq u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .value (dataIn),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  assign differs = !shown_vld || (shown_mode != hexMode) || (shown_val != dataIn);

  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (differs && !conv_busy) begin
          conv_start = 1'b1;
          state_nxt  = ST_SHIFT;
        end
      end
      ST_SHIFT: if (conv_done) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    if (cap_mode) begin
      new_digs  = {8'h00, cap_val};
      new_blank = {2'b11, (cap_val[7:4] == 4'h0), 1'b0};
    end else begin
      new_digs  = {4'h0, conv_bcd};
      new_blank = {1'b1, (conv_bcd[11:8] == 4'h0), (conv_bcd[11:4] == 8'h00), 1'b0};
    end
  end

  // control: FSM, busy, blanking and shown-value validity
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      blank     <= 4'b1111;
      shown_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt != ST_IDLE);
      if (state == ST_DONE) begin
        blank     <= new_blank;
        shown_vld <= 1'b1;
      end
    end
  end

  // data: captured request, shown value and digit nibbles (guarded by valid/blank)
  always_ff @(posedge clk) begin
    if (conv_start) begin
      cap_mode <= hexMode;
      cap_val  <= dataIn;
    end
    if (state == ST_DONE) begin
      digs       <= new_digs;
      shown_mode <= cap_mode;
      shown_val  <= cap_val;
    end
  end

  // scan: refresh counter, digit index and registered drivers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
      idx      <= 2'd0;
      an       <= 4'b1110;
      seg      <= SEG_BLANK;
    end else begin
      if (scan_cnt == LAST) begin
        scan_cnt <= '0;
        idx      <= idx + 2'd1;
      end else begin
        scan_cnt <= scan_cnt + 1'b1;
      end
      an  <= ~(4'b0001 << idx);
      seg <= blank[idx] ? SEG_BLANK : seg_decode(digs[{idx, 2'b00} +: 4]);
    end
  end

endmodule

// File: doc/calc_display.md
CALC_DISPLAY -- requirements
Module: calc_display

Interface
REQ-001 Parameter: REFRESH_CNT, default 100000, clocks each digit stays enabled (1 kHz per digit at 100 MHz); legal range >= 2.
REQ-002 clk  input  1  single system clock, all state on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 dataIn  input  8  unsigned calculator result to display.
REQ-005 hexMode  input  1  1 = show hex, 0 = show unsigned decimal.
REQ-006 seg  output  7  segment drive {g,f,e,d,c,b,a}, active-low, registered.
REQ-007 an  output  4  digit enables, active-low one-hot, an[0] = rightmost digit, registered.
REQ-008 busy  output  1  high while a conversion is in progress, registered.

Function
REQ-009 The block SHALL hold a shown-value register {mode,value} and four 4-bit digit registers plus a blank flag per digit.
REQ-010 The FSM SHALL have states IDLE, SHIFT, DONE; busy = 1 in SHIFT and DONE, else 0.
REQ-011 IDLE: if {hexMode,dataIn} differs from the shown-value register, latch both and go to SHIFT; otherwise stay.
REQ-012 SHIFT: exactly 8 cycles of double-dabble (add 3 to any BCD nibble >= 5, then shift left one bit), driven by a 3-bit iteration counter; then go to DONE.
REQ-013 In hex mode the SHIFT cycles SHALL still run (fixed latency) but the result SHALL be the raw nibbles.
REQ-014 DONE: write digit registers and blank flags in one cycle, update shown-value, return to IDLE.
REQ-015 Latency: new digits visible on seg 10 clocks after the edge where the difference is first sampled (plus scan position).
REQ-016 Decimal: digits 2..0 = hundreds, tens, ones; digit 3 always blank; leading zeros blanked; digit 0 never blanked.
REQ-017 Hex: digits 1..0 = dataIn[7:4], dataIn[3:0]; digits 3..2 blank; digit 1 blanked when zero.
REQ-018 Changes of dataIn or hexMode during SHIFT/DONE SHALL be ignored for the running conversion; IDLE re-compares and starts a new conversion on the next cycle.
REQ-019 Scan counter SHALL count 0..REFRESH_CNT-1 and wrap; on wrap the 2-bit digit index SHALL increment mod 4.
REQ-020 an SHALL equal ~(1 << index); seg SHALL be the decode of the selected digit, or 7'h7F if blanked.
REQ-021 Segment codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.

Reset
REQ-022 On rst low: state IDLE, busy 0, scan counter 0, index 0, an 4'b1110, seg 7'h7F, all digits blanked, shown-value set to an impossible marker (extra valid bit cleared) so the first post-reset cycle always triggers a conversion.
REQ-023 Reset asserted mid-conversion SHALL abort it immediately; no partial digits reach the display.

Structure
REQ-024 Segment code table and FSM state encodings SHALL live in the shared calc package/include used by the calculator family.
REQ-025 Double-dabble datapath SHALL be a sub-module bin2bcd_seq (start, value in, busy, done, 12-bit BCD out); seven-segment decode stays in calc_display.

Verification (REFRESH_CNT = 4 unless noted)
REQ-026 Reset release, dataIn 0, decimal -> busy high 9 clocks, then digit 0 shows 1000000, digits 1..3 show 7F.
REQ-027 dataIn 255 decimal -> 10 clocks later digits 2,1,0 = 0100100, 0010010, 0010010; digit 3 = 7F.
REQ-028 dataIn 8'hA7, hexMode 1 -> digit 1 = 0001000, digit 0 = 1111000, digits 3..2 = 7F.
REQ-029 dataIn 12, change to 34 three clocks into SHIFT -> display shows 12 first, then 34 after a second 10-clock conversion; no other value appears.
REQ-030 Scan: an sequence 1110, 1101, 1011, 0111, 1110, each held exactly 4 clocks; reset asserted mid-conversion -> an 1110, seg 7F, busy 0 asynchronously.
